// File: rtl/trash_fetch.sv
// trash_fetch: byte-loaded program store feeding one instruction per cycle to the execute stage
module trash_fetch #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic             load_valid,
    input  logic [7:0]       load_byte,
    output logic [WIDTH-1:0] instr,
    output logic [AW-1:0]    instr_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             jump_valid,
    input  logic [AW-1:0]    jump_addr,
    output logic [AW:0]      prog_len,
    output logic             fault
);
    typedef enum logic [1:0] {LOAD, EMPTY, BUBBLE, FETCH} state_t;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    state_t           state_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    pc_q;
    logic             byte_phase_q;
    logic [7:0]       low_q;
    logic [AW:0]      prog_len_q;
    logic [WIDTH-1:0] instr_q;
    logic [AW-1:0]    instr_pc_q;
    logic             instr_valid_q;
    logic             fault_q;
    logic [AW:0]      pc_inc_d;
    logic [AW-1:0]    next_pc_d;
    logic             jump_ok_d;
    logic [AW-1:0]    jump_pc_d;
    logic             word_wr_d;
    // sequential pc wraps at the loaded program length; out-of-range jumps fall back to 0
    always_comb begin
        pc_inc_d  = {1'b0, pc_q} + 1'b1;
        next_pc_d = (pc_inc_d == prog_len_q) ? '0 : pc_inc_d[AW-1:0];
        jump_ok_d = {1'b0, jump_addr} < prog_len_q;
        jump_pc_d = jump_ok_d ? jump_addr : '0;
        word_wr_d = !reset && load_en && state_q == LOAD && load_valid && byte_phase_q;
    end
    // program memory takes a full word once its high byte arrives; never cleared
    always_ff @(posedge clk) begin
        if (word_wr_d) mem_q[wr_ptr_q] <= {load_byte, low_q};
    end
    // control FSM: load packing, bubble on entry/jump, handshake-driven fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= EMPTY;
            wr_ptr_q      <= '0;
            pc_q          <= '0;
            byte_phase_q  <= 1'b0;
            low_q         <= '0;
            prog_len_q    <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else if (load_en) begin
            state_q       <= LOAD;
            instr_valid_q <= 1'b0;
            if (state_q != LOAD) begin
                wr_ptr_q     <= '0;
                byte_phase_q <= 1'b0;
                prog_len_q   <= '0;
                fault_q      <= 1'b0;
            end else if (load_valid) begin
                byte_phase_q <= !byte_phase_q;
                if (!byte_phase_q) begin
                    low_q <= load_byte;
                end else begin
                    wr_ptr_q   <= wr_ptr_q + 1'b1;
                    prog_len_q <= (prog_len_q == FULL) ? prog_len_q : prog_len_q + 1'b1;
                end
            end
        end else begin
            case (state_q)
                LOAD: begin
                    byte_phase_q <= 1'b0;
                    pc_q         <= '0;
                    state_q      <= (prog_len_q == '0) ? EMPTY : BUBBLE;
                end
                BUBBLE, FETCH: begin
                    if (jump_valid) begin
                        instr_valid_q <= 1'b0;
                        pc_q          <= jump_pc_d;
                        fault_q       <= fault_q | !jump_ok_d;
                        state_q       <= BUBBLE;
                    end else if (state_q == BUBBLE) begin
                        instr_q       <= mem_q[pc_q];
                        instr_pc_q    <= pc_q;
                        instr_valid_q <= 1'b1;
                        state_q       <= FETCH;
                    end else if (instr_ready) begin
                        instr_q    <= mem_q[next_pc_d];
                        instr_pc_q <= next_pc_d;
                        pc_q       <= next_pc_d;
                    end
                end
                default: instr_valid_q <= 1'b0;
            endcase
        end
    end
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign prog_len    = prog_len_q;
    assign fault       = fault_q;
endmodule

// File: tb/tb_trash_fetch.sv
// tb_trash_fetch: vector table, hand sequences and a randomized reference-model run
module tb_trash_fetch;
    logic        clk = 1'b0;
    logic        reset, load_en, load_valid, instr_ready, jump_valid;
    logic [7:0]  load_byte;
    logic [2:0]  jump_addr, instr_pc;
    logic [15:0] instr;
    logic        instr_valid, fault;
    logic [3:0]  prog_len;
    int checks = 0;
    int errors = 0;

    trash_fetch dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_valid(load_valid),
        .load_byte(load_byte), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .jump_valid(jump_valid), .jump_addr(jump_addr),
        .prog_len(prog_len), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic le, lv; logic [7:0] b; logic rdy, jv; logic [2:0] ja;
        logic ev; logic [15:0] ei; logic [2:0] ep; logic [3:0] el; logic ef;
    } vec_t;
    vec_t tbl [31];

    function automatic vec_t v(logic le, logic lv, logic [7:0] b, logic rdy, logic jv, logic [2:0] ja,
                               logic ev, logic [15:0] ei, logic [2:0] ep, logic [3:0] el, logic ef);
        vec_t r;
        r.le = le; r.lv = lv; r.b = b; r.rdy = rdy; r.jv = jv; r.ja = ja;
        r.ev = ev; r.ei = ei; r.ep = ep; r.el = el; r.ef = ef;
        return r;
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(logic le, logic lv, logic [7:0] b, logic rdy, logic jv, logic [2:0] ja);
        load_en = le; load_valid = lv; load_byte = b; instr_ready = rdy; jump_valid = jv; jump_addr = ja;
    endtask

    task automatic do_reset();
        drive(0, 0, 8'h00, 0, 0, 3'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // reference model: program contents, words loaded since LOAD entry, and run progress
    logic [15:0] mmem [8];
    bit m_in_load, m_idle, m_pending, m_valid, m_fault, m_have_low;
    logic [7:0] m_low;
    int m_words, m_pc;

    function automatic int plen();
        return (m_words > 8) ? 8 : m_words;
    endfunction

    task automatic model_reset();
        m_in_load = 0; m_idle = 1; m_pending = 0; m_valid = 0; m_fault = 0;
        m_have_low = 0; m_words = 0; m_pc = 0;
    endtask

    task automatic model_step();
        if (load_en) begin
            if (!m_in_load) begin
                m_in_load = 1; m_words = 0; m_have_low = 0; m_fault = 0; m_valid = 0;
            end else if (load_valid) begin
                if (!m_have_low) begin
                    m_low = load_byte; m_have_low = 1;
                end else begin
                    mmem[m_words % 8] = {load_byte, m_low}; m_words++; m_have_low = 0;
                end
            end
        end else if (m_in_load) begin
            m_in_load = 0; m_have_low = 0; m_pc = 0;
            m_idle = (plen() == 0); m_pending = !m_idle;
        end else if (!m_idle) begin
            if (jump_valid) begin
                m_valid = 0; m_pending = 1;
                if (int'(jump_addr) < plen()) m_pc = jump_addr;
                else begin m_pc = 0; m_fault = 1; end
            end else if (m_pending) begin
                m_pending = 0; m_valid = 1;
            end else if (instr_ready) begin
                m_pc = (m_pc + 1) % plen();
            end
        end
    endtask

    task automatic rand_step();
        @(posedge clk);
        model_step();
        #1;
        chk("rand valid", 16'(instr_valid), 16'(m_valid));
        chk("rand prog_len", 16'(prog_len), 16'(plen()));
        chk("rand fault", 16'(fault), 16'(m_fault));
        if (m_valid) begin
            chk("rand instr", instr, mmem[m_pc]);
            chk("rand pc", 16'(instr_pc), 16'(m_pc));
        end
    endtask

    initial begin
        tbl[0]  = v(0,0,8'h00,0,1,3'd5, 0,16'h0000,3'd0,4'd0,0);
        tbl[1]  = v(0,0,8'h00,0,0,3'd0, 0,16'h0000,3'd0,4'd0,0);
        tbl[2]  = v(1,0,8'h00,0,0,3'd0, 0,16'h0000,3'd0,4'd0,0);
        tbl[3]  = v(1,1,8'h34,0,0,3'd0, 0,16'h0000,3'd0,4'd0,0);
        tbl[4]  = v(1,1,8'h12,0,0,3'd0, 0,16'h0000,3'd0,4'd1,0);
        tbl[5]  = v(1,1,8'h78,0,0,3'd0, 0,16'h0000,3'd0,4'd1,0);
        tbl[6]  = v(1,1,8'h56,0,0,3'd0, 0,16'h0000,3'd0,4'd2,0);
        tbl[7]  = v(1,1,8'hBC,0,0,3'd0, 0,16'h0000,3'd0,4'd2,0);
        tbl[8]  = v(1,1,8'h9A,0,0,3'd0, 0,16'h0000,3'd0,4'd3,0);
        tbl[9]  = v(0,0,8'h00,1,0,3'd0, 0,16'h0000,3'd0,4'd3,0);
        tbl[10] = v(0,0,8'h00,1,0,3'd0, 1,16'h1234,3'd0,4'd3,0);
        tbl[11] = v(0,0,8'h00,1,0,3'd0, 1,16'h5678,3'd1,4'd3,0);
        tbl[12] = v(0,0,8'h00,1,0,3'd0, 1,16'h9ABC,3'd2,4'd3,0);
        tbl[13] = v(0,0,8'h00,1,0,3'd0, 1,16'h1234,3'd0,4'd3,0);
        tbl[14] = v(0,0,8'h00,1,0,3'd0, 1,16'h5678,3'd1,4'd3,0);
        tbl[15] = v(0,0,8'h00,0,0,3'd0, 1,16'h5678,3'd1,4'd3,0);
        tbl[16] = v(0,0,8'h00,0,0,3'd0, 1,16'h5678,3'd1,4'd3,0);
        tbl[17] = v(0,0,8'h00,1,0,3'd0, 1,16'h9ABC,3'd2,4'd3,0);
        tbl[18] = v(0,0,8'h00,1,0,3'd0, 1,16'h1234,3'd0,4'd3,0);
        tbl[19] = v(0,0,8'h00,1,1,3'd2, 0,16'h0000,3'd0,4'd3,0);
        tbl[20] = v(0,0,8'h00,0,0,3'd0, 1,16'h9ABC,3'd2,4'd3,0);
        tbl[21] = v(0,0,8'h00,0,1,3'd6, 0,16'h0000,3'd0,4'd3,1);
        tbl[22] = v(0,0,8'h00,0,0,3'd0, 1,16'h1234,3'd0,4'd3,1);
        tbl[23] = v(1,0,8'h00,0,0,3'd0, 0,16'h0000,3'd0,4'd0,0);
        tbl[24] = v(1,1,8'h11,0,0,3'd0, 0,16'h0000,3'd0,4'd0,0);
        tbl[25] = v(1,1,8'h22,0,0,3'd0, 0,16'h0000,3'd0,4'd1,0);
        tbl[26] = v(1,1,8'h33,0,0,3'd0, 0,16'h0000,3'd0,4'd1,0);
        tbl[27] = v(0,0,8'h00,1,0,3'd0, 0,16'h0000,3'd0,4'd1,0);
        tbl[28] = v(0,0,8'h00,1,0,3'd0, 1,16'h2211,3'd0,4'd1,0);
        tbl[29] = v(0,0,8'h00,1,0,3'd0, 1,16'h2211,3'd0,4'd1,0);
        tbl[30] = v(1,0,8'h00,1,0,3'd0, 0,16'h0000,3'd0,4'd0,0);

        do_reset();
        chk("reset valid", 16'(instr_valid), 16'd0);
        chk("reset prog_len", 16'(prog_len), 16'd0);
        chk("reset fault", 16'(fault), 16'd0);
        chk("reset instr", instr, 16'h0000);
        chk("reset pc", 16'(instr_pc), 16'd0);

        for (int i = 0; i < 31; i++) begin
            drive(tbl[i].le, tbl[i].lv, tbl[i].b, tbl[i].rdy, tbl[i].jv, tbl[i].ja);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d valid", i), 16'(instr_valid), 16'(tbl[i].ev));
            chk($sformatf("vec%0d prog_len", i), 16'(prog_len), 16'(tbl[i].el));
            chk($sformatf("vec%0d fault", i), 16'(fault), 16'(tbl[i].ef));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d instr", i), instr, tbl[i].ei);
                chk($sformatf("vec%0d pc", i), 16'(instr_pc), 16'(tbl[i].ep));
            end
        end

        // nine words: the ninth overwrites entry 0 and length saturates at 8
        for (int k = 1; k <= 9; k++) begin
            drive(1, 1, 8'(k), 0, 0, 3'd0);
            @(posedge clk);
            #1 drive(1, 1, 8'h00, 0, 0, 3'd0);
            @(posedge clk);
            #1;
        end
        chk("nine prog_len", 16'(prog_len), 16'd8);
        drive(0, 0, 8'h00, 1, 0, 3'd0);
        @(posedge clk);
        #1 chk("nine bubble valid", 16'(instr_valid), 16'd0);
        @(posedge clk);
        #1;
        chk("nine pc0 valid", 16'(instr_valid), 16'd1);
        chk("nine pc0 instr", instr, 16'h0009);
        chk("nine pc0 pc", 16'(instr_pc), 16'd0);
        @(posedge clk);
        #1 chk("nine pc1 instr", instr, 16'h0002);
        repeat (6) @(posedge clk);
        #1 chk("nine pc7 instr", instr, 16'h0008);
        @(posedge clk);
        #1;
        chk("nine wrap instr", instr, 16'h0009);
        chk("nine wrap pc", 16'(instr_pc), 16'd0);

        do_reset();
        model_reset();
        for (int it = 0; it < 40; it++) begin
            int n = $urandom_range(1, 22);
            int m = $urandom_range(3, 25);
            for (int c = 0; c < n; c++) begin
                drive(1, 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 5) == 0), 3'($urandom));
                rand_step();
            end
            for (int c = 0; c < m; c++) begin
                drive(0, 1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0), 3'($urandom));
                rand_step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/trash_fetch.md
# trash_fetch

Instruction-fetch and program-store stage sitting directly upstream of the trash CPU execute stage. Accepts program bytes from the dedicated input pins while in load mode and packs them into 16-bit instruction words in an 8-entry program memory. In run mode, presents one instruction per cycle to the execute stage over a valid/ready handshake, and accepts jump redirects back from it.

## Interface
- `DEPTH`, 8: program memory entries (power of two; address width `AW` = log2(DEPTH) = 3)
- `WIDTH`, 16: instruction width; built from two 8-bit load bytes

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `load_en`  in  1  1 = load mode, 0 = run mode
- `load_valid`  in  1  `load_byte` is valid this cycle (load mode only)
- `load_byte`  in  8  program byte; low byte of a word first, then high byte
- `instr`  out  16  instruction to execute stage
- `instr_pc`  out  3  address of `instr`
- `instr_valid`  out  1  `instr` / `instr_pc` valid
- `instr_ready`  in  1  execute stage consumes `instr` when `instr_valid & instr_ready`
- `jump_valid`  in  1  redirect request from execute stage
- `jump_addr`  in  3  redirect target
- `prog_len`  out  4  number of complete words loaded, 0..8
- `fault`  out  1  sticky; set by an out-of-range jump

## Operation
- States: LOAD, EMPTY, BUBBLE, FETCH.
- Reset: state EMPTY; `wr_ptr`, `pc`, `byte_phase`, `prog_len`, `instr`, `instr_pc`, `instr_valid`, `fault` all 0. Memory is not cleared.
- Any state, `load_en`=1: next state LOAD. On the entry cycle, clear `wr_ptr`, `byte_phase`, `prog_len`, `fault`, and `instr_valid`.
- LOAD, `load_valid`=1:
  - `byte_phase`=0: latch the byte as the low half; set `byte_phase` to 1.
  - `byte_phase`=1: write `{load_byte, low}` to `mem[wr_ptr]`; increment `wr_ptr` modulo 8; `prog_len` = min(`prog_len`+1, 8); clear `byte_phase`.
  - The 9th word overwrites entry 0; `prog_len` stays 8.
- LOAD, `load_en`=0:
  - Drop any dangling low byte.
  - `prog_len`=0: go to EMPTY.
  - Otherwise: `pc` <= 0 and go to BUBBLE.
- EMPTY: `instr_valid`=0. Ignore `jump_valid`. Leave only via `load_en`.
- BUBBLE: `instr` <= `mem[pc]`, `instr_pc` <= `pc`, `instr_valid` <= 1; go to FETCH.
- FETCH: `instr_valid`=1. On handshake, compute `next` = (`pc`+1 == `prog_len`) ? 0 : `pc`+1. Same cycle: `instr` <= `mem[next]`, `pc` <= `next`. Throughput is 1 instruction/cycle. Without handshake, outputs hold stable.
- Jump (BUBBLE or FETCH, `jump_valid`=1):
  - `instr_valid` <= 0 and go to BUBBLE.
  - `pc` <= `jump_addr` if `jump_addr` < `prog_len`; otherwise `pc` <= 0 and `fault` <= 1.
- Priority: `reset` > `load_en` > `jump_valid` > handshake advance. A handshake in the same cycle as a jump still counts as consumed; the jump decides the next `pc`.
- `load_valid` in run mode is ignored.

## Timing
- `load_en` sampled 0 in cycle N, with `prog_len`>0: BUBBLE in N+1; `instr_valid`=1 with `mem[0]` in N+2.
- Jump sampled in cycle N: `instr_valid`=0 in N+1; target instruction valid in N+2. Jump penalty is 1 bubble cycle.
- Memory write: the word is readable by a fetch starting in the cycle after the high-byte write.
- `prog_len` updates in the cycle after the high byte is sampled.
- `fault` sets in the cycle after the offending jump and holds until `reset` or entry into LOAD.
- `instr` and `instr_valid` are registered; there is no combinational path from `instr_ready` or `jump_valid` to any output.

## Test plan
- Reset, then `load_en`=0 -> EMPTY, `instr_valid`=0, `prog_len`=0 indefinitely; `jump_valid`=1 with addr 5 changes nothing.
- Load bytes 0x34,0x12,0x78,0x56,0xBC,0x9A, then `load_en`=0, `instr_ready`=1 -> `prog_len`=3. Two cycles later the stream is `instr` 0x1234/pc0, 0x5678/pc1, 0x9ABC/pc2, 0x1234/pc0 (wrap at `prog_len`), one per cycle.
- Same program, `instr_ready` toggled 1,0,0,1 -> `instr` holds 0x5678 through the stall; no skipped or duplicated pc.
- Run with `prog_len`=3, `jump_valid`=1 with `jump_addr`=2 while presenting pc0 -> next cycle `instr_valid`=0; the cycle after, 0x9ABC/pc2. `jump_addr`=6 -> `pc`=0, `fault`=1, cleared by re-entering LOAD.
- Load 9 words (0x0001..0x0009), then run -> `prog_len`=8; pc0 presents 0x0009.
- Load 0x11,0x22,0x33, then `load_en`=0 -> `prog_len`=1, only 0x2211 fetched. Assert `load_en` mid-run -> `instr_valid`=0 next cycle, `prog_len`=0.
